// File: rtl/gauss_fu_scheduler.sv
// gauss_fu_scheduler
// Shares one iterative Gauss functional unit among N requesters. It picks one
// request round-robin, launches the unit with that operand, waits for fu_done,
// then holds the result until the consumer takes it. A unit that never
// completes is abandoned after TIMEOUT cycles and raises a sticky err.
//
// Ports:
//   clk, preset           clock, synchronous active-high reset
//   req/req_data/req_tag  per-requester request, operand and tag (packed, i*W)
//   gnt                   one-hot acceptance pulse
//   fu_start/fu_operand   launch pulse and latched operand to the unit
//   fu_done/fu_result/fu_pred  completion handshake from the unit
//   res_valid/res_ready   result handshake; res_data/res_pred/res_tag/res_src
//   busy                  high outside IDLE
//   err                   sticky timeout flag
module gauss_fu_scheduler #(
    parameter int unsigned N       = 4,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned SW     = (N > 1) ? $clog2(N) : 1,
    localparam int unsigned CW     = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               preset,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N*TAG_W-1:0] req_tag,
    output logic [N-1:0]       gnt,
    output logic               fu_start,
    output logic [WIDTH-1:0]   fu_operand,
    input  logic               fu_done,
    input  logic [WIDTH-1:0]   fu_result,
    input  logic               fu_pred,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_pred,
    output logic [TAG_W-1:0]   res_tag,
    output logic [SW-1:0]      res_src,
    output logic               busy,
    output logic               err
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [SW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     gnt_d;
    logic             start_d;
    logic [WIDTH-1:0] operand_d;
    logic             valid_d;
    logic [WIDTH-1:0] data_d;
    logic             pred_d;
    logic [TAG_W-1:0] tag_d;
    logic [SW-1:0]    src_d;
    logic             err_d;

    logic             win_found;
    int unsigned      win_idx;
    int unsigned      scan_idx;

    // Round-robin pick: first set bit scanning ptr, ptr+1, ... with wrap.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_idx = (32'(ptr_q) + i) % N;
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        start_d   = 1'b0;
        operand_d = fu_operand;
        valid_d   = res_valid;
        data_d    = res_data;
        pred_d    = res_pred;
        tag_d     = res_tag;
        src_d     = res_src;
        err_d     = err;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    start_d        = 1'b1;
                    operand_d      = req_data[win_idx*WIDTH +: WIDTH];
                    tag_d          = req_tag[win_idx*TAG_W +: TAG_W];
                    src_d          = SW'(win_idx);
                    ptr_d          = SW'((win_idx + 1) % N);
                    cnt_d          = '0;
                    state_d        = StWait;
                end
            end
            StWait: begin
                // Completion wins over a timeout landing on the same edge.
                if (fu_done) begin
                    data_d  = fu_result;
                    pred_d  = fu_pred;
                    valid_d = 1'b1;
                    state_d = StResp;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StResp: begin
                if (res_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            cnt_q      <= '0;
            gnt        <= '0;
            fu_start   <= 1'b0;
            fu_operand <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_pred   <= 1'b0;
            res_tag    <= '0;
            res_src    <= '0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt        <= gnt_d;
            fu_start   <= start_d;
            fu_operand <= operand_d;
            res_valid  <= valid_d;
            res_data   <= data_d;
            res_pred   <= pred_d;
            res_tag    <= tag_d;
            res_src    <= src_d;
            err        <= err_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_gauss_fu_scheduler.sv
module tb_gauss_fu_scheduler;
    localparam int N       = 4;
    localparam int WIDTH   = 16;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic               clk = 1'b0;
    logic               preset;
    logic [N-1:0]       req;
    logic [N*WIDTH-1:0] req_data;
    logic [N*TAG_W-1:0] req_tag;
    logic [N-1:0]       gnt;
    logic               fu_start;
    logic [WIDTH-1:0]   fu_operand;
    logic               fu_done;
    logic [WIDTH-1:0]   fu_result;
    logic               fu_pred;
    logic               res_valid;
    logic               res_ready;
    logic [WIDTH-1:0]   res_data;
    logic               res_pred;
    logic [TAG_W-1:0]   res_tag;
    logic [1:0]         res_src;
    logic               busy;
    logic               err;

    gauss_fu_scheduler #(.N(N), .WIDTH(WIDTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .preset(preset), .req(req), .req_data(req_data), .req_tag(req_tag),
        .gnt(gnt), .fu_start(fu_start), .fu_operand(fu_operand), .fu_done(fu_done),
        .fu_result(fu_result), .fu_pred(fu_pred), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_pred(res_pred), .res_tag(res_tag),
        .res_src(res_src), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int ptr_m  = 0;   // model round-robin pointer
    bit err_m  = 0;   // model sticky error
    logic [WIDTH-1:0] dm [N];
    logic [TAG_W-1:0] tm [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [WIDTH-1:0] d, input logic [TAG_W-1:0] t);
        req[i] = 1'b1;
        dm[i] = d;
        tm[i] = t;
        req_data[i*WIDTH +: WIDTH] = d;
        req_tag[i*TAG_W +: TAG_W] = t;
    endtask

    task automatic wait_gnt(output int idx, output bit ok);
        ok = 0;
        idx = -1;
        for (int c = 0; c < 20 && !ok; c++) begin
            tick();
            if (gnt != '0) begin
                ok = 1;
                for (int i = 0; i < N; i++) if (gnt[i]) idx = i;
            end
        end
    endtask

    // fu_done sampled at the lat-th edge after the grant edge.
    task automatic complete(input int lat, input logic [WIDTH-1:0] r, input logic p);
        repeat (lat - 1) tick();
        fu_done = 1'b1;
        fu_result = r;
        fu_pred = p;
        tick();
        fu_done = 1'b0;
        fu_result = '0;
        fu_pred = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic do_reset();
        preset = 1'b1;
        tick();
        tick();
        preset = 1'b0;
        ptr_m = 0;
        err_m = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({gnt, fu_start, res_valid, res_pred, err, busy} !== 9'b0) begin
            $display("FAIL reset_ctrl: got %b want 0", {gnt, fu_start, res_valid, res_pred, err, busy});
        end else passed++;
        total++;
        if ({fu_operand, res_data, res_tag, res_src} !== '0) begin
            $display("FAIL reset_data: got %h want 0", {fu_operand, res_data, res_tag, res_src});
        end else passed++;
    endtask

    task automatic test_single();
        int w;
        bit ok;
        set_req(0, 16'h0001, 4'd5);
        wait_gnt(w, ok);
        req[0] = 1'b0;
        total++;
        if (!ok || {gnt, fu_start, fu_operand} !== {4'b0001, 1'b1, 16'h0001}) begin
            $display("FAIL single_grant: got gnt=%b start=%b op=%h want 0001 1 0001",
                     gnt, fu_start, fu_operand);
        end else passed++;
        ptr_m = 1;
        tick();
        total++;
        if ({gnt, fu_start, busy, fu_operand} !== {4'b0, 1'b0, 1'b1, 16'h0001}) begin
            $display("FAIL single_pulse: got gnt=%b start=%b busy=%b op=%h want 0000 0 1 0001",
                     gnt, fu_start, busy, fu_operand);
        end else passed++;
        complete(3, 16'h00AA, 1'b1);
        total++;
        if ({res_valid, res_data, res_pred, res_tag, res_src} !== {1'b1, 16'h00AA, 1'b1, 4'd5, 2'd0})
        begin
            $display("FAIL single_result: got v=%b d=%h p=%b t=%0d s=%0d want 1 00aa 1 5 0",
                     res_valid, res_data, res_pred, res_tag, res_src);
        end else passed++;
        handshake();
        total++;
        if ({res_valid, busy} !== 2'b00) begin
            $display("FAIL single_release: got v=%b busy=%b want 0 0", res_valid, busy);
        end else passed++;
    endtask

    task automatic test_contention();
        int w, exp_w;
        bit ok;
        int order [3] = '{0, 1, 3};
        do_reset();
        set_req(0, 16'h1000, 4'd1);
        set_req(1, 16'h1111, 4'd2);
        set_req(3, 16'h3333, 4'd3);
        for (int k = 0; k < 3; k++) begin
            exp_w = pick(req, ptr_m);
            wait_gnt(w, ok);
            total++;
            if (!ok || w !== exp_w || w !== order[k] || fu_operand !== dm[exp_w]) begin
                $display("FAIL contention_grant%0d: got %0d op=%h want %0d op=%h",
                         k, w, fu_operand, order[k], dm[exp_w]);
            end else passed++;
            req[exp_w] = 1'b0;
            ptr_m = (exp_w + 1) % N;
            complete(2, 16'hBEE0 + 16'(k), k[0]);
            total++;
            if ({res_valid, res_src, res_tag} !== {1'b1, 2'(exp_w), tm[exp_w]}) begin
                $display("FAIL contention_src%0d: got v=%b s=%0d t=%0d want 1 %0d %0d",
                         k, res_valid, res_src, res_tag, exp_w, tm[exp_w]);
            end else passed++;
            handshake();
        end
        // After requester 3 the pointer wraps, so all-set picks requester 0.
        for (int i = 0; i < N; i++) set_req(i, 16'h2000 + 16'(i), 4'(i));
        wait_gnt(w, ok);
        total++;
        if (!ok || w !== 0) begin
            $display("FAIL contention_wrap: got %0d want 0", w);
        end else passed++;
        req = '0;
        ptr_m = 1;
        complete(1, 16'h0, 1'b0);
        handshake();
    endtask

    task automatic test_back_pressure();
        int w;
        bit ok;
        int bad;
        do_reset();
        set_req(0, 16'h0A0A, 4'd7);
        wait_gnt(w, ok);
        req[0] = 1'b0;
        ptr_m = 1;
        set_req(1, 16'h0B0B, 4'd9);
        complete(2, 16'h5A5A, 1'b0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if ({res_valid, res_data, res_pred, res_tag, res_src, gnt, busy} !==
                {1'b1, 16'h5A5A, 1'b0, 4'd7, 2'd0, 4'b0, 1'b1}) bad++;
            tick();
        end
        total++;
        if (bad !== 0) begin
            $display("FAIL bp_hold: got %0d unstable cycles want 0", bad);
        end else passed++;
        handshake();
        total++;
        if ({res_valid, gnt} !== 5'b0) begin
            $display("FAIL bp_release: got v=%b gnt=%b want 0 0000", res_valid, gnt);
        end else passed++;
        tick();
        total++;
        if ({gnt, fu_start, fu_operand} !== {4'b0010, 1'b1, 16'h0B0B}) begin
            $display("FAIL bp_next_grant: got gnt=%b start=%b op=%h want 0010 1 0b0b",
                     gnt, fu_start, fu_operand);
        end else passed++;
        req[1] = 1'b0;
        ptr_m = 2;
        complete(1, 16'h0, 1'b0);
        handshake();
    endtask

    task automatic test_idle();
        int bad;
        int w, exp_w;
        bit ok;
        req = '0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if ({busy, gnt, fu_start} !== 6'b0) bad++;
        end
        total++;
        if (bad !== 0) begin
            $display("FAIL idle_quiet: got %0d active cycles want 0", bad);
        end else passed++;
        for (int i = 0; i < N; i++) set_req(i, 16'h4000 + 16'(i), 4'(i + 8));
        exp_w = pick(req, ptr_m);
        wait_gnt(w, ok);
        total++;
        if (!ok || w !== exp_w) begin
            $display("FAIL idle_ptr: got %0d want %0d", w, exp_w);
        end else passed++;
        req = '0;
        ptr_m = (exp_w + 1) % N;
        complete(1, 16'h0, 1'b0);
        handshake();
    endtask

    task automatic test_timeout();
        int w, exp_w;
        bit ok;
        bit seen_valid;
        set_req(2, 16'h2222, 4'd4);
        exp_w = pick(req, ptr_m);
        wait_gnt(w, ok);
        req = '0;
        ptr_m = (exp_w + 1) % N;
        seen_valid = 0;
        repeat (TIMEOUT - 1) begin
            tick();
            if (res_valid) seen_valid = 1;
        end
        total++;
        if ({err, busy} !== 2'b01) begin
            $display("FAIL timeout_early: got err=%b busy=%b want 0 1", err, busy);
        end else passed++;
        tick();
        if (res_valid) seen_valid = 1;
        err_m = 1;
        total++;
        if ({err, busy, seen_valid} !== 3'b100) begin
            $display("FAIL timeout_fire: got err=%b busy=%b valid_seen=%b want 1 0 0",
                     err, busy, seen_valid);
        end else passed++;
        set_req(3, 16'h3C3C, 4'd6);
        exp_w = pick(req, ptr_m);
        wait_gnt(w, ok);
        req = '0;
        ptr_m = (exp_w + 1) % N;
        complete(2, 16'h7777, 1'b1);
        total++;
        if (!ok || {res_valid, res_data, res_tag, res_src, err} !==
            {1'b1, 16'h7777, 4'd6, 2'(exp_w), err_m}) begin
            $display("FAIL timeout_recover: got v=%b d=%h t=%0d s=%0d err=%b want 1 7777 6 %0d 1",
                     res_valid, res_data, res_tag, res_src, err, exp_w);
        end else passed++;
        handshake();
    endtask

    task automatic test_reset_mid();
        int w, exp_w;
        bit ok;
        set_req(0, 16'h0F0F, 4'd3);
        wait_gnt(w, ok);
        req = '0;
        tick();
        tick();
        preset = 1'b1;
        tick();
        preset = 1'b0;
        ptr_m = 0;
        err_m = 0;
        total++;
        if ({gnt, fu_start, res_valid, res_pred, err, busy, fu_operand, res_data, res_tag, res_src}
            !== '0) begin
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {gnt, fu_start, res_valid, res_pred, err, busy, fu_operand, res_data});
        end else passed++;
        fu_done = 1'b1;
        fu_result = 16'hDEAD;
        fu_pred = 1'b1;
        tick();
        fu_done = 1'b0;
        tick();
        total++;
        if ({res_valid, busy, res_data} !== 18'b0) begin
            $display("FAIL reset_mid_done_ignored: got v=%b busy=%b d=%h want 0 0 0000",
                     res_valid, busy, res_data);
        end else passed++;
        set_req(0, 16'h0101, 4'd1);
        set_req(1, 16'h0202, 4'd2);
        exp_w = pick(req, ptr_m);
        wait_gnt(w, ok);
        total++;
        if (!ok || w !== exp_w || w !== 0) begin
            $display("FAIL reset_mid_ptr: got %0d want 0", w);
        end else passed++;
        req = '0;
        ptr_m = 1;
        complete(1, 16'h0, 1'b0);
        handshake();
    endtask

    task automatic test_random();
        int w, exp_w, lat, dly;
        bit ok;
        logic [N-1:0] add;
        logic [WIDTH-1:0] r;
        logic p;
        int bad = 0;
        for (int t = 0; t < 40; t++) begin
            add = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                if (add[i] && !req[i]) set_req(i, 16'($urandom), 4'($urandom));
            if (req == '0) set_req(0, 16'($urandom), 4'($urandom));
            exp_w = pick(req, ptr_m);
            wait_gnt(w, ok);
            total++;
            if (!ok || w !== exp_w || fu_operand !== dm[exp_w] || fu_start !== 1'b1) begin
                $display("FAIL random_grant%0d: got %0d op=%h want %0d op=%h",
                         t, w, fu_operand, exp_w, dm[exp_w]);
            end else passed++;
            req[exp_w] = 1'b0;
            ptr_m = (exp_w + 1) % N;
            lat = $urandom_range(1, 5);
            r = 16'($urandom);
            p = 1'($urandom);
            complete(lat, r, p);
            dly = $urandom_range(0, 3);
            repeat (dly) begin
                tick();
                if (!res_valid || gnt != '0) bad++;
            end
            total++;
            if ({res_valid, res_data, res_pred, res_tag, res_src} !==
                {1'b1, r, p, tm[exp_w], 2'(exp_w)}) begin
                $display("FAIL random_result%0d: got v=%b d=%h p=%b t=%0d s=%0d want 1 %h %b %0d %0d",
                         t, res_valid, res_data, res_pred, res_tag, res_src, r, p, tm[exp_w], exp_w);
            end else passed++;
            handshake();
        end
        total++;
        if (bad !== 0 || err !== err_m) begin
            $display("FAIL random_hold_err: got bad=%0d err=%b want 0 %b", bad, err, err_m);
        end else passed++;
        req = '0;
    endtask

    initial begin
        preset = 1'b1;
        req = '0;
        req_data = '0;
        req_tag = '0;
        fu_done = 1'b0;
        fu_result = '0;
        fu_pred = 1'b0;
        res_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_back_pressure();
        test_idle();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/gauss_fu_scheduler.md
# gauss_fu_scheduler

Issue scheduler that shares one iterative Gauss functional unit among N requesters in the superscalar core. It arbitrates requests round-robin, launches the unit with the winning operand, waits for its completion, and returns the result with the requester's tag and index. It also flags a functional unit that never completes.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- TAG_W, 4, requester tag width
- TIMEOUT, 64, max cycles in WAIT before error (>=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- preset  in  1  reset, synchronous, active-high
- req  in  N  per-requester request; held with data/tag until matching gnt
- req_data  in  N*WIDTH  operands, requester i at bits [i*WIDTH +: WIDTH]
- req_tag  in  N*TAG_W  tags, requester i at bits [i*TAG_W +: TAG_W]
- gnt  out  N  one-hot, one-cycle acceptance pulse
- fu_start  out  1  one-cycle launch pulse to the Gauss unit
- fu_operand  out  WIDTH  latched operand, stable from launch until next launch
- fu_done  in  1  unit completion, sampled on clk rising edge
- fu_result  in  WIDTH  unit result, valid with fu_done
- fu_pred  in  1  unit prediction bit, valid with fu_done
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  latched result
- res_pred  out  1  latched prediction
- res_tag  out  TAG_W  tag of the served request
- res_src  out  clog2(N)  index of the served requester
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, WAIT, RESP. Round-robin pointer ptr is in 0..N-1.
- IDLE: if any req bit is set at the edge, the winner is the first set bit scanning ptr, ptr+1, … with wrap at N. On that edge:
  - gnt[winner] and fu_start go high for one cycle.
  - fu_operand, res_tag and res_src latch the winner's operand, tag and index.
  - ptr becomes (winner+1) mod N.
  - The timeout counter clears and the state moves to WAIT.
- With no req set, the scheduler stays in IDLE and ptr is unchanged.
- WAIT: the counter increments each cycle. fu_done=1 at an edge latches res_data/res_pred from fu_result/fu_pred, sets res_valid and moves to RESP.
  - If the counter reaches TIMEOUT with no fu_done, err is set, res_valid stays 0 and the state returns to IDLE.
- RESP: res_valid and all res_* are held. res_valid&res_ready at an edge clears res_valid and returns to IDLE.
- fu_done is ignored in IDLE and RESP.
- req is ignored outside IDLE. A pending request waits; it is never dropped.
- err is cleared only by preset. Service continues after err is set.
- preset (dominant in every state, including mid-WAIT and mid-RESP):
  - state IDLE, ptr 0, counter 0.
  - gnt, fu_start, res_valid, res_pred and err go to 0.
  - fu_operand, res_data, res_tag and res_src go to 0.
  - busy goes to 0.
  - A unit operation in flight is abandoned. Its later fu_done is ignored because the scheduler is in IDLE.

## Timing
- Request to grant: req sampled high at edge k gives gnt/fu_start high during cycle k..k+1.
- The counter starts at the same edge k.
- Completion: fu_done sampled at edge m gives res_valid high from edge m.
- Turnaround: a handshake at edge r returns to IDLE; the earliest next grant is at edge r+1. Back-to-back service therefore costs 1 idle cycle.
- The Gauss unit may run on ~clk. The scheduler samples fu_done/fu_result only on the clk rising edge, so the unit must hold them across that edge.
- Simultaneous requests: exactly one grant per IDLE edge. Losers keep req high and are served in round-robin order.

## Test plan
- Single request:
  - Stimulus: req=0001, data 0x0001, tag 5; fu_done at edge 4 of WAIT with result 0x00AA, pred 1.
  - Response: gnt=0001 and fu_start for 1 cycle, fu_operand=0x0001. Then res_valid with res_data=0x00AA, res_pred=1, res_tag=5, res_src=0.
- Contention (N=4):
  - Stimulus: req=1011 held, with each request dropped after its gnt.
  - Response: grant order 0, 1, 3. res_src matches each grant. ptr wraps to 0 after requester 3.
- Back-pressure:
  - Stimulus: res_ready=0 for 5 cycles after res_valid, while another req is pending.
  - Response: res_* stable, no gnt. Next gnt one edge after the res_ready handshake.
- Timeout:
  - Stimulus: TIMEOUT=8, fu_done never asserted.
  - Response: err=1 after 8 WAIT cycles, res_valid never set, return to IDLE. The next request is served normally and err stays 1.
- Reset mid-operation:
  - Stimulus: preset for 1 cycle in WAIT, then fu_done pulses in IDLE.
  - Response: all outputs 0, fu_done ignored, no res_valid. The next grant goes to the lowest set req bit (ptr=0).
- Idle behaviour:
  - Stimulus: req=0 for 20 cycles.
  - Response: busy=0, gnt=0, fu_start=0 throughout, ptr unchanged.
